// File: rtl/pixel_fifo.sv
// pixel_fifo
//   Single-clock synchronous FIFO for RGB565 pixels. The line generator
//   writes into it and the scanout reader pops from it. fifo_full asserts
//   early so that writes already in flight in the writer's pipeline still fit.
//   flush clears the contents at frame start. Sticky overflow and underflow
//   flags record a dropped write and a pop while empty.
// Ports
//   clk, reset              clock (rising edge) and async active-high reset
//   fifo_write, fifo_data   push strobe and pixel
//   fifo_full               almost-full: free entries <= FULL_MARGIN
//   rd_en                   pop request
//   rd_data, rd_valid       popped pixel, valid one cycle after an accepted pop
//   empty, level            occupancy status (level is 0..DEPTH)
//   flush                   synchronous clear of contents, highest priority
//   clr_flags               synchronous clear of overflow/underflow
//   overflow, underflow     sticky error flags
module pixel_fifo #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 9,
   parameter int FULL_MARGIN = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_write,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   input  logic                  flush,
   input  logic                  clr_flags,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   LVL_MAX  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH - FULL_MARGIN);
   localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  push_ok, pop_ok;

   always_comb begin
      // Flush masks both requests so that neither can set a flag.
      pop_ok  = rd_en && !flush && (level_q != '0);
      // At level==DEPTH a same-cycle pop frees the slot the push needs.
      push_ok = fifo_write && !flush && ((level_q != LVL_MAX) || pop_ok);

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = pop_ok;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            // The read sees the pre-edge contents, so a push to the same
            // slot at level==DEPTH cannot corrupt the popped word.
            rd_data_d = mem[rd_ptr_q];
         end
         if (push_ok && !pop_ok)      level_d = level_q + LVL_ONE;
         else if (pop_ok && !push_ok) level_d = level_q - LVL_ONE;

         // Clear first so a same-cycle error event wins.
         if (clr_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
         if (fifo_write && !push_ok)         overflow_d  = 1'b1;
         if (rd_en && (level_q == '0))       underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; stale words are never visible past level.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= fifo_data;
   end

   assign fifo_full = (level_q >= LVL_FULL);
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
